bullet_controller: RTL and testbench
====================================

Name: bullet_controller

Overview:
Per-tank bullet engine, one instance per player. It sits directly upstream of the wall/tank collision checker. It drives X_Bullet, Y_Bullet and bullet_dir into that checker and consumes the checker's registered-per-frame hit code. It owns spawn, per-frame motion, despawn, lifetime and fire cooldown, and outputs bullet state to the sprite renderer.

Parameters:
STEP, 5, pixels moved per frame tick (must equal the collision checker's bullet step)
BULLET_SIZE, 8, bullet square edge in pixels
TANK_SIZE, 32, tank square edge in pixels
SCREEN_W, 640, playfield width
SCREEN_H, 480, playfield height
LIFETIME, 120, frame ticks before forced despawn
COOLDOWN, 15, frame ticks after despawn before next fire is accepted
MAX_BOUNCES, 3, wall reflections allowed (used only with the optional feature)

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
frame_clk  in  1  VGA vertical sync; asynchronous to Clk
fire  in  1  player fire key, level
X_Tank  in  10  owning tank left edge
Y_Tank  in  10  owning tank top edge
tank_dir  in  3  tank facing: 1 up, 2 right, 3 left, 4 down, others invalid
hit  in  2  from collision checker: 01 none, 00 wall, 10 tank, 11 treated as 01
X_Bullet  out  10  bullet left edge
Y_Bullet  out  10  bullet top edge
bullet_dir  out  3  bullet direction code; 0 whenever not flying
bullet_active  out  1  high in FLY
tank_hit_pulse  out  1  one Clk-cycle pulse when the bullet despawns on hit==10

Behaviour:
- Reset, async: X/Y=0, bullet_dir=0, bullet_active=0, tank_hit_pulse=0, state IDLE, all counters and flags 0.
- Tick: frame_clk passes through a 2-flop synchroniser. tick is a 1-cycle pulse on the synchronised rising edge. All motion and state changes occur only on Clk edges with tick=1.
- fire_pending: set on a Clk-domain rising edge of fire. Cleared on every tick, whether consumed or not.
- State IDLE: on tick with fire_pending=1, tank_dir in 1..4 and spawn legal -> FLY. Load position, bullet_dir=tank_dir, life_cnt=0, bounce_cnt=0. Otherwise stay.
- Spawn positions (all arithmetic 11-bit, no wrap):
  - up: X=X_Tank+12, Y=Y_Tank-8; legal iff Y_Tank>=8.
  - down: X=X_Tank+12, Y=Y_Tank+32; legal iff Y_Tank+40<=SCREEN_H.
  - right: X=X_Tank+32, Y=Y_Tank+12; legal iff X_Tank+40<=SCREEN_W.
  - left: X=X_Tank-8, Y=Y_Tank+12; legal iff X_Tank>=8.
  - The offset 12 is (TANK_SIZE-BULLET_SIZE)/2.
- State FLY, on tick, first match wins:
  1. hit==10 -> COOLDOWN; tank_hit_pulse=1 for that cycle.
  2. hit==00 -> COOLDOWN.
  3. Next step leaves the screen -> COOLDOWN. Conditions: up with Y<STEP; left with X<STEP; down with Y+BULLET_SIZE+STEP>SCREEN_H; right with X+BULLET_SIZE+STEP>SCREEN_W.
  4. life_cnt==LIFETIME-1 -> COOLDOWN.
  5. Otherwise advance the position by STEP along bullet_dir and increment life_cnt.
- Entering COOLDOWN: bullet_active=0, bullet_dir=0, X/Y hold last value, cd_cnt=0.
- State COOLDOWN: each tick increments cd_cnt. On the tick where cd_cnt==COOLDOWN-1 -> IDLE, so a new bullet can spawn no earlier than COOLDOWN+1 ticks after despawn.
- fire during FLY or COOLDOWN: ignored. No queuing beyond the next tick.
- Outputs are registered. hit is sampled only on the tick, so the one-frame collision lookahead is required and sufficient.
- tank_dir changes after spawn do not affect a flying bullet.

Optional Feature:
BULLET_BOUNCE_EN.
- Defined: on hit==00 with bounce_cnt<MAX_BOUNCES, stay in FLY. Reverse bullet_dir (1<->4, 2<->3), increment bounce_cnt, do not advance position that tick, increment life_cnt. Once bounce_cnt==MAX_BOUNCES, a wall hit -> COOLDOWN. Screen-edge exits still despawn.
- Undefined: every wall hit despawns; bounce_cnt is absent.

Test Plan:
- Reset_n low mid-FLY, asynchronously -> all outputs 0 immediately, state IDLE. The first tick after release with no fire keeps bullet_active=0.
- Tank (100,200), tank_dir=1, pulse fire, tick -> X=112, Y=192, bullet_dir=1, active=1. Next tick Y=187, X unchanged.
- FLY, hit=00 on a tick -> active=0, bullet_dir=0. Fire pulses before each of the next 15 ticks are ignored. A fire pulse before the 16th tick spawns.
- Y_Tank=4, tank_dir=1, fire -> no spawn, active stays 0. Y_Tank=8 -> spawns at Y=0. Next tick despawns on the screen-edge rule.
- Open field, right fire, hit=01 throughout -> despawn on tick 120 after spawn, having advanced 119*5 px or fewer; any edge exit wins earlier.
- hit=10 in FLY -> tank_hit_pulse high exactly one Clk cycle, active=0. With BULLET_BOUNCE_EN, hit=00 three times reverses direction each time; the fourth hit despawns.

Source files
------------

// File: rtl/bullet_controller.sv
// bullet_controller: per-tank bullet engine (spawn, motion, despawn,
// lifetime, fire cooldown). All state changes happen on the Clk edge where the
// synchronised frame tick is high.
// Optional feature macro: BULLET_BOUNCE_EN (wall reflections up to MAX_BOUNCES).
module bullet_controller #(
  parameter int STEP        = 5,
  parameter int BULLET_SIZE = 8,
  parameter int TANK_SIZE   = 32,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int LIFETIME    = 120,
  parameter int COOLDOWN    = 15,
  parameter int MAX_BOUNCES = 3
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       fire,
  input  logic [9:0] X_Tank,
  input  logic [9:0] Y_Tank,
  input  logic [2:0] tank_dir,
  input  logic [1:0] hit,
  output logic [9:0] X_Bullet,
  output logic [9:0] Y_Bullet,
  output logic [2:0] bullet_dir,
  output logic       bullet_active,
  output logic       tank_hit_pulse
);

  localparam int LIFE_W = $clog2(LIFETIME + 1);
  localparam int CD_W   = $clog2(COOLDOWN + 1);

  localparam logic [10:0] P_STEP = 11'(STEP);
  localparam logic [10:0] P_BS   = 11'(BULLET_SIZE);
  localparam logic [10:0] P_TS   = 11'(TANK_SIZE);
  localparam logic [10:0] P_SW   = 11'(SCREEN_W);
  localparam logic [10:0] P_SH   = 11'(SCREEN_H);
  localparam logic [9:0]  P_OFF  = 10'((TANK_SIZE - BULLET_SIZE) / 2);

  typedef enum logic [1:0] {S_IDLE, S_FLY, S_COOL} state_t;

  state_t            r_state, w_state_nxt;
  logic [9:0]        r_x, r_y, w_x_nxt, w_y_nxt;
  logic [2:0]        r_dir, w_dir_nxt;
  logic              r_active, w_active_nxt;
  logic              r_pulse, w_pulse_nxt;
  logic [LIFE_W-1:0] r_life, w_life_nxt;
  logic [CD_W-1:0]   r_cd, w_cd_nxt;
  logic              r_fc_meta, r_fc_sync, r_fc_prev;
  logic              r_fire_d, r_fire_pend;
  logic              w_tick, w_despawn;
  logic [9:0]        w_sx, w_sy;
  logic              w_spawn_ok, w_edge;
  logic [10:0]       w_xt, w_yt, w_bx, w_by;
`ifdef BULLET_BOUNCE_EN
  localparam int BNC_W = $clog2(MAX_BOUNCES + 1);
  logic [BNC_W-1:0]  r_bounce, w_bounce_nxt;
`endif

  assign w_tick = r_fc_sync & ~r_fc_prev;
  assign w_xt   = {1'b0, X_Tank};
  assign w_yt   = {1'b0, Y_Tank};
  assign w_bx   = {1'b0, r_x};
  assign w_by   = {1'b0, r_y};

  // Frame-clock synchroniser plus edge history, and the fire edge latch.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_fc_meta   <= 1'b0;
      r_fc_sync   <= 1'b0;
      r_fc_prev   <= 1'b0;
      r_fire_d    <= 1'b0;
      r_fire_pend <= 1'b0;
    end else begin
      r_fc_meta <= frame_clk;
      r_fc_sync <= r_fc_meta;
      r_fc_prev <= r_fc_sync;
      r_fire_d  <= fire;
      if (w_tick)
        r_fire_pend <= 1'b0;
      else if (fire && !r_fire_d)
        r_fire_pend <= 1'b1;
    end
  end

  // Spawn position and legality from the tank pose (11-bit, no wrap).
  always_comb begin
    w_sx       = '0;
    w_sy       = '0;
    w_spawn_ok = 1'b0;
    case (tank_dir)
      3'd1: begin
        w_sx = X_Tank + P_OFF;  w_sy = Y_Tank - P_BS[9:0];
        w_spawn_ok = (w_yt >= P_BS);
      end
      3'd2: begin
        w_sx = X_Tank + P_TS[9:0];  w_sy = Y_Tank + P_OFF;
        w_spawn_ok = (w_xt + P_TS + P_BS <= P_SW);
      end
      3'd3: begin
        w_sx = X_Tank - P_BS[9:0];  w_sy = Y_Tank + P_OFF;
        w_spawn_ok = (w_xt >= P_BS);
      end
      3'd4: begin
        w_sx = X_Tank + P_OFF;  w_sy = Y_Tank + P_TS[9:0];
        w_spawn_ok = (w_yt + P_TS + P_BS <= P_SH);
      end
      default: ;
    endcase
  end

  // Would the next step along the current direction leave the screen.
  always_comb begin
    w_edge = 1'b0;
    case (r_dir)
      3'd1:    w_edge = (w_by < P_STEP);
      3'd2:    w_edge = (w_bx + P_BS + P_STEP > P_SW);
      3'd3:    w_edge = (w_bx < P_STEP);
      3'd4:    w_edge = (w_by + P_BS + P_STEP > P_SH);
      default: w_edge = 1'b0;
    endcase
  end

  // Next-state and next-output logic; everything holds except on a tick.
  always_comb begin
    w_state_nxt  = r_state;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_dir_nxt    = r_dir;
    w_active_nxt = r_active;
    w_pulse_nxt  = 1'b0;
    w_life_nxt   = r_life;
    w_cd_nxt     = r_cd;
    w_despawn    = 1'b0;
`ifdef BULLET_BOUNCE_EN
    w_bounce_nxt = r_bounce;
`endif
    if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (r_fire_pend && w_spawn_ok) begin
            w_state_nxt  = S_FLY;
            w_x_nxt      = w_sx;
            w_y_nxt      = w_sy;
            w_dir_nxt    = tank_dir;
            w_active_nxt = 1'b1;
            w_life_nxt   = '0;
`ifdef BULLET_BOUNCE_EN
            w_bounce_nxt = '0;
`endif
          end
        end
        S_FLY: begin
          if (hit == 2'b10) begin
            w_despawn   = 1'b1;
            w_pulse_nxt = 1'b1;
          end else if (hit == 2'b00) begin
`ifdef BULLET_BOUNCE_EN
            if (r_bounce < BNC_W'(MAX_BOUNCES)) begin
              // 1<->4 and 2<->3 are both "5 minus code".
              w_dir_nxt    = 3'd5 - r_dir;
              w_bounce_nxt = r_bounce + 1'b1;
              w_life_nxt   = r_life + 1'b1;
            end else begin
              w_despawn = 1'b1;
            end
`else
            w_despawn = 1'b1;
`endif
          end else if (w_edge) begin
            w_despawn = 1'b1;
          end else if (r_life >= LIFE_W'(LIFETIME - 1)) begin
            // >= rather than == so a bounce on the last frame cannot skip past it.
            w_despawn = 1'b1;
          end else begin
            w_life_nxt = r_life + 1'b1;
            case (r_dir)
              3'd1:    w_y_nxt = r_y - P_STEP[9:0];
              3'd2:    w_x_nxt = r_x + P_STEP[9:0];
              3'd3:    w_x_nxt = r_x - P_STEP[9:0];
              3'd4:    w_y_nxt = r_y + P_STEP[9:0];
              default: ;
            endcase
          end
          if (w_despawn) begin
            w_state_nxt  = S_COOL;
            w_active_nxt = 1'b0;
            w_dir_nxt    = '0;
            w_cd_nxt     = '0;
          end
        end
        S_COOL: begin
          if (r_cd == CD_W'(COOLDOWN - 1))
            w_state_nxt = S_IDLE;
          else
            w_cd_nxt = r_cd + 1'b1;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= S_IDLE;
      r_x      <= '0;
      r_y      <= '0;
      r_dir    <= '0;
      r_active <= 1'b0;
      r_pulse  <= 1'b0;
      r_life   <= '0;
      r_cd     <= '0;
`ifdef BULLET_BOUNCE_EN
      r_bounce <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_dir    <= w_dir_nxt;
      r_active <= w_active_nxt;
      r_pulse  <= w_pulse_nxt;
      r_life   <= w_life_nxt;
      r_cd     <= w_cd_nxt;
`ifdef BULLET_BOUNCE_EN
      r_bounce <= w_bounce_nxt;
`endif
    end
  end

  assign X_Bullet       = r_x;
  assign Y_Bullet       = r_y;
  assign bullet_dir     = r_dir;
  assign bullet_active  = r_active;
  assign tank_hit_pulse = r_pulse;

endmodule

// File: tb/tb_bullet_controller.sv
// Directed testbench for bullet_controller.
module tb_bullet_controller;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic       fire = 1'b0;
  logic [9:0] X_Tank = '0;
  logic [9:0] Y_Tank = '0;
  logic [2:0] tank_dir = '0;
  logic [1:0] hit = 2'b01;
  logic [9:0] X_Bullet, Y_Bullet;
  logic [2:0] bullet_dir;
  logic       bullet_active, tank_hit_pulse;

  int total = 0;
  int bad = 0;
  int pulse_seen = 0;

  bullet_controller #(.STEP(5), .BULLET_SIZE(8), .TANK_SIZE(32), .SCREEN_W(640),
                      .SCREEN_H(480), .LIFETIME(120), .COOLDOWN(15), .MAX_BOUNCES(3)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .fire(fire),
    .X_Tank(X_Tank), .Y_Tank(Y_Tank), .tank_dir(tank_dir), .hit(hit),
    .X_Bullet(X_Bullet), .Y_Bullet(Y_Bullet), .bullet_dir(bullet_dir),
    .bullet_active(bullet_active), .tank_hit_pulse(tank_hit_pulse)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge Clk) frame_clk = 1'b1;
    repeat (6) begin @(negedge Clk); if (tank_hit_pulse) pulse_seen++; end
    frame_clk = 1'b0;
    repeat (3) begin @(negedge Clk); if (tank_hit_pulse) pulse_seen++; end
  endtask

  task automatic pulse_fire();
    @(negedge Clk) fire = 1'b1;
    @(negedge Clk) fire = 1'b0;
    @(negedge Clk);
  endtask

  task automatic cooldown_wait();
    repeat (15) tick();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    total++; if (X_Bullet !== 10'd0) begin bad++; $display("FAIL rst_x got=%0d exp=0", X_Bullet); end
    total++; if (Y_Bullet !== 10'd0) begin bad++; $display("FAIL rst_y got=%0d exp=0", Y_Bullet); end
    total++; if (bullet_dir !== 3'd0) begin bad++; $display("FAIL rst_dir got=%0d exp=0", bullet_dir); end
    total++; if (bullet_active !== 1'b0) begin bad++; $display("FAIL rst_active got=%0d exp=0", bullet_active); end
    total++; if (tank_hit_pulse !== 1'b0) begin bad++; $display("FAIL rst_pulse got=%0d exp=0", tank_hit_pulse); end
  endtask

  task automatic test_spawn_up();
    X_Tank = 10'd100; Y_Tank = 10'd200; tank_dir = 3'd1; hit = 2'b01;
    pulse_fire(); tick();
    total++; if (X_Bullet !== 10'd112) begin bad++; $display("FAIL spawn_x got=%0d exp=112", X_Bullet); end
    total++; if (Y_Bullet !== 10'd192) begin bad++; $display("FAIL spawn_y got=%0d exp=192", Y_Bullet); end
    total++; if (bullet_dir !== 3'd1) begin bad++; $display("FAIL spawn_dir got=%0d exp=1", bullet_dir); end
    total++; if (bullet_active !== 1'b1) begin bad++; $display("FAIL spawn_active got=%0d exp=1", bullet_active); end
    tank_dir = 3'd2;
    tick();
    total++; if (Y_Bullet !== 10'd187) begin bad++; $display("FAIL move_y got=%0d exp=187", Y_Bullet); end
    total++; if (X_Bullet !== 10'd112) begin bad++; $display("FAIL move_x got=%0d exp=112", X_Bullet); end
    total++; if (bullet_dir !== 3'd1) begin bad++; $display("FAIL move_dir_kept got=%0d exp=1", bullet_dir); end
  endtask

  task automatic test_wall_cooldown();
    hit = 2'b00; tank_dir = 3'd1;
`ifdef BULLET_BOUNCE_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bullet_dir !== ((i % 2 == 0) ? 3'd4 : 3'd1)) begin bad++; $display("FAIL bounce_dir%0d got=%0d exp=%0d", i, bullet_dir, (i % 2 == 0) ? 4 : 1); end
      total++; if (bullet_active !== 1'b1 || Y_Bullet !== 10'd187) begin bad++; $display("FAIL bounce_hold%0d got=%0d/%0d exp=1/187", i, bullet_active, Y_Bullet); end
    end
`endif
    tick();
    hit = 2'b01;
    total++; if (bullet_active !== 1'b0) begin bad++; $display("FAIL wall_active got=%0d exp=0", bullet_active); end
    total++; if (bullet_dir !== 3'd0) begin bad++; $display("FAIL wall_dir got=%0d exp=0", bullet_dir); end
    total++; if (X_Bullet !== 10'd112 || Y_Bullet !== 10'd187) begin bad++; $display("FAIL wall_hold got=%0d,%0d exp=112,187", X_Bullet, Y_Bullet); end
    for (int k = 1; k <= 15; k++) begin
      pulse_fire(); tick();
      total++; if (bullet_active !== 1'b0) begin bad++; $display("FAIL cooldown_tick%0d got=%0d exp=0", k, bullet_active); end
    end
    pulse_fire(); tick();
    total++; if (bullet_active !== 1'b1 || Y_Bullet !== 10'd192) begin bad++; $display("FAIL respawn got=%0d/%0d exp=1/192", bullet_active, Y_Bullet); end
  endtask

  task automatic test_tank_hit();
    pulse_seen = 0; hit = 2'b10;
    tick();
    hit = 2'b01;
    total++; if (pulse_seen !== 1) begin bad++; $display("FAIL hit_pulse_cycles got=%0d exp=1", pulse_seen); end
    total++; if (bullet_active !== 1'b0) begin bad++; $display("FAIL hit_active got=%0d exp=0", bullet_active); end
    total++; if (bullet_dir !== 3'd0) begin bad++; $display("FAIL hit_dir got=%0d exp=0", bullet_dir); end
    cooldown_wait();
  endtask

  task automatic test_edges();
    X_Tank = 10'd100; Y_Tank = 10'd4; tank_dir = 3'd1;
    pulse_fire(); tick();
    total++; if (bullet_active !== 1'b0) begin bad++; $display("FAIL up_illegal got=%0d exp=0", bullet_active); end
    Y_Tank = 10'd8;
    tick();
    total++; if (bullet_active !== 1'b0) begin bad++; $display("FAIL pending_cleared got=%0d exp=0", bullet_active); end
    pulse_fire(); tick();
    total++; if (bullet_active !== 1'b1 || Y_Bullet !== 10'd0 || X_Bullet !== 10'd112) begin bad++; $display("FAIL up_boundary got=%0d/%0d,%0d exp=1/112,0", bullet_active, X_Bullet, Y_Bullet); end
    tick();
    total++; if (bullet_active !== 1'b0 || Y_Bullet !== 10'd0) begin bad++; $display("FAIL top_exit got=%0d/%0d exp=0/0", bullet_active, Y_Bullet); end
    cooldown_wait();
    Y_Tank = 10'd440; tank_dir = 3'd4;
    pulse_fire(); tick();
    total++; if (bullet_active !== 1'b1 || Y_Bullet !== 10'd472 || X_Bullet !== 10'd112) begin bad++; $display("FAIL down_boundary got=%0d/%0d,%0d exp=1/112,472", bullet_active, X_Bullet, Y_Bullet); end
    tick();
    total++; if (bullet_active !== 1'b0 || Y_Bullet !== 10'd472) begin bad++; $display("FAIL bottom_exit got=%0d/%0d exp=0/472", bullet_active, Y_Bullet); end
    cooldown_wait();
    X_Tank = 10'd4; Y_Tank = 10'd200; tank_dir = 3'd3;
    pulse_fire(); tick();
    total++; if (bullet_active !== 1'b0) begin bad++; $display("FAIL left_illegal got=%0d exp=0", bullet_active); end
    X_Tank = 10'd100; tank_dir = 3'd0;
    pulse_fire(); tick();
    total++; if (bullet_active !== 1'b0) begin bad++; $display("FAIL bad_dir got=%0d exp=0", bullet_active); end
    X_Tank = 10'd8; tank_dir = 3'd3;
    pulse_fire(); tick();
    total++; if (bullet_active !== 1'b1 || X_Bullet !== 10'd0 || Y_Bullet !== 10'd212 || bullet_dir !== 3'd3) begin bad++; $display("FAIL left_boundary got=%0d/%0d,%0d/%0d exp=1/0,212/3", bullet_active, X_Bullet, Y_Bullet, bullet_dir); end
    tick();
    total++; if (bullet_active !== 1'b0) begin bad++; $display("FAIL left_exit got=%0d exp=0", bullet_active); end
    cooldown_wait();
  endtask

  task automatic test_lifetime();
    X_Tank = 10'd0; Y_Tank = 10'd200; tank_dir = 3'd2;
    pulse_fire(); tick();
    total++; if (X_Bullet !== 10'd32 || Y_Bullet !== 10'd212) begin bad++; $display("FAIL right_spawn got=%0d,%0d exp=32,212", X_Bullet, Y_Bullet); end
    repeat (119) tick();
    total++; if (bullet_active !== 1'b1 || X_Bullet !== 10'd627) begin bad++; $display("FAIL life_119 got=%0d/%0d exp=1/627", bullet_active, X_Bullet); end
    tick();
    total++; if (bullet_active !== 1'b0 || X_Bullet !== 10'd627 || Y_Bullet !== 10'd212) begin bad++; $display("FAIL life_end got=%0d/%0d,%0d exp=0/627,212", bullet_active, X_Bullet, Y_Bullet); end
    cooldown_wait();
  endtask

  task automatic test_right_edge();
    X_Tank = 10'd100; Y_Tank = 10'd200; tank_dir = 3'd2;
    pulse_fire(); tick();
    repeat (100) tick();
    total++; if (bullet_active !== 1'b1 || X_Bullet !== 10'd632) begin bad++; $display("FAIL right_last got=%0d/%0d exp=1/632", bullet_active, X_Bullet); end
    tick();
    total++; if (bullet_active !== 1'b0 || X_Bullet !== 10'd632) begin bad++; $display("FAIL right_exit got=%0d/%0d exp=0/632", bullet_active, X_Bullet); end
    cooldown_wait();
  endtask

  task automatic test_reset_midfly();
    X_Tank = 10'd100; Y_Tank = 10'd200; tank_dir = 3'd1;
    pulse_fire(); tick(); tick();
    total++; if (bullet_active !== 1'b1 || Y_Bullet !== 10'd187) begin bad++; $display("FAIL pre_reset got=%0d/%0d exp=1/187", bullet_active, Y_Bullet); end
    @(negedge Clk); #2 Reset_n = 1'b0;
    #1;
    total++; if (bullet_active !== 1'b0 || bullet_dir !== 3'd0 || X_Bullet !== 10'd0 || Y_Bullet !== 10'd0) begin bad++; $display("FAIL async_reset got=%0d/%0d/%0d,%0d exp=0/0/0,0", bullet_active, bullet_dir, X_Bullet, Y_Bullet); end
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    tick();
    total++; if (bullet_active !== 1'b0) begin bad++; $display("FAIL post_reset_tick got=%0d exp=0", bullet_active); end
  endtask

  initial begin
    test_reset();
    test_spawn_up();
    test_wall_cooldown();
    test_tank_hit();
    test_edges();
    test_lifetime();
    test_right_edge();
    test_reset_midfly();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
